// File: rtl/seg7_scan_mux_if.sv
// Core-side and pad-side signal bundle for the 4-digit seven-segment scanner.
interface seg7_scan_mux_if #(
  parameter int DIGITS = 4
);
  logic                  enable;
  logic                  load;
  logic [4*DIGITS-1:0]   value;
  logic [DIGITS-1:0]     dp;
  logic                  blank_lz;
  logic [DIGITS-1:0]     io_sel;
  logic [7:0]            io_seg;
  logic                  scan_tick;

  // Core logic / testbench side: drives display data, observes pads
  modport master (
    output enable, load, value, dp, blank_lz,
    input  io_sel, io_seg, scan_tick
  );

  // Scanner side
  modport slave (
    input  enable, load, value, dp, blank_lz,
    output io_sel, io_seg, scan_tick
  );
endinterface

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed seven-segment scanner with frame-synchronous double
// buffering, leading-zero suppression and an all-off guard interval at the
// start of every digit slot to suppress ghosting.
module seg7_scan_mux #(
  parameter int DIGITS       = 4,
  parameter int DIV          = 50000,
  parameter int BLANK_CYCLES = 8
) (
  input  logic            clk,
  input  logic            rst,
  seg7_scan_mux_if.slave  bus
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
  localparam logic [DW-1:0] DIG_LAST  = DW'(DIGITS - 1);

  // Slot phase, derived from the prescaler position
  localparam logic [0:0] ST_GUARD = 1'b0;
  localparam logic [0:0] ST_DRIVE = 1'b1;

  // Scan position
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] dig_q, dig_d;
  logic          tick_q, tick_d;
  logic          wrap;
  logic [0:0]    slot_state;

  // Active (displayed) and pending (next frame) buffers
  logic [4*DIGITS-1:0] act_val_q, act_val_d, pend_val_q, pend_val_d;
  logic [DIGITS-1:0]   act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
  logic                act_blz_q, act_blz_d, pend_blz_q, pend_blz_d;
  logic                pend_valid_q, pend_valid_d;

  // Registered pad outputs
  logic [DIGITS-1:0] sel_q, sel_d;
  logic [7:0]        seg_q, seg_d;

  // Per-digit view of the active buffer
  logic [3:0]        nib [DIGITS];
  logic [DIGITS-1:0] zero_v;
  logic [DIGITS-1:0] blank_v;

  // Hex nibble to segments, gfedcba, 1 = lit
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  // A digit above 0 is blanked only if it and every digit to its left are zero
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    assign nib[gi]    = act_val_q[4*gi +: 4];
    assign zero_v[gi] = (nib[gi] == 4'h0);
    if (gi == 0) begin : g_lsd
      assign blank_v[gi] = 1'b0;
    end else begin : g_upper
      assign blank_v[gi] = act_blz_q & (&zero_v[DIGITS-1:gi]);
    end
  end

  assign wrap       = bus.enable && (cnt_q == CNT_LAST) && (dig_q == DIG_LAST);
  assign slot_state = (cnt_q < CNT_BLANK) ? ST_GUARD : ST_DRIVE;

  // Prescaler and digit index; disabled scanning parks at digit 0, count 0
  always_comb begin
    cnt_d  = cnt_q;
    dig_d  = dig_q;
    tick_d = 1'b0;
    if (!bus.enable) begin
      cnt_d = '0;
      dig_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d  = '0;
      tick_d = 1'b1;
      dig_d  = (dig_q == DIG_LAST) ? '0 : dig_q + 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Double buffer: pending moves to active only on the frame wrap; a load on
  // the wrap cycle lands in pending after the old pending has been consumed
  always_comb begin
    act_val_d    = act_val_q;
    act_dp_d     = act_dp_q;
    act_blz_d    = act_blz_q;
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_blz_d   = pend_blz_q;
    pend_valid_d = pend_valid_q;
    if (wrap && pend_valid_q) begin
      act_val_d    = pend_val_q;
      act_dp_d     = pend_dp_q;
      act_blz_d    = pend_blz_q;
      pend_valid_d = 1'b0;
    end
    if (bus.load) begin
      pend_val_d   = bus.value;
      pend_dp_d    = bus.dp;
      pend_blz_d   = bus.blank_lz;
      pend_valid_d = 1'b1;
    end
  end

  // Pad drive: dark while disabled or in the guard phase of a slot
  always_comb begin
    sel_d = '1;
    seg_d = 8'hFF;
    if (bus.enable && slot_state == ST_DRIVE) begin
      sel_d = ~(DIGITS'(1) << dig_q);
      seg_d = ~{act_dp_q[dig_q], blank_v[dig_q] ? 7'h00 : hex7(nib[dig_q])};
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      dig_q        <= '0;
      tick_q       <= 1'b0;
      act_val_q    <= '0;
      act_dp_q     <= '0;
      act_blz_q    <= 1'b0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_blz_q   <= 1'b0;
      pend_valid_q <= 1'b0;
      sel_q        <= '1;
      seg_q        <= 8'hFF;
    end else begin
      cnt_q        <= cnt_d;
      dig_q        <= dig_d;
      tick_q       <= tick_d;
      act_val_q    <= act_val_d;
      act_dp_q     <= act_dp_d;
      act_blz_q    <= act_blz_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_blz_q   <= pend_blz_d;
      pend_valid_q <= pend_valid_d;
      sel_q        <= sel_d;
      seg_q        <= seg_d;
    end
  end

  assign bus.io_sel    = sel_q;
  assign bus.io_seg    = seg_q;
  assign bus.scan_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Self-checking bench for seg7_scan_mux (DIGITS=4, DIV=8, BLANK_CYCLES=2).
module tb_seg7_scan_mux;
  localparam int DIGITS = 4;
  localparam int DIV    = 8;
  localparam int BLANK  = 2;
  localparam int FRAME  = DIGITS * DIV;
  localparam int NVEC   = 9;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg7_scan_mux_if #(.DIGITS(DIGITS)) bus();

  seg7_scan_mux #(.DIGITS(DIGITS), .DIV(DIV), .BLANK_CYCLES(BLANK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Input record plus expected io_seg per digit, packed {d3,d2,d1,d0}
  typedef struct {
    logic [15:0] value;
    logic [3:0]  dp;
    logic        blz;
    logic [31:0] exp_seg;
  } vec_t;

  typedef struct {
    logic [3:0] sel;
    logic [7:0] seg;
  } exp_t;

  vec_t vecs [NVEC];
  exp_t sb [$];

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;
  int since_tick = 100;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  task automatic timeout_fail(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: timeout waiting for DUT", nm);
  endtask

  // Scoreboard: one expected {sel, seg} per digit, in scan order
  task automatic push_frame(input logic [31:0] e);
    logic [3:0] one;
    exp_t x;
    one = 4'b0001;
    for (int d = 0; d < DIGITS; d++) begin
      x.sel = ~(one << d);
      x.seg = e[8*d +: 8];
      sb.push_back(x);
    end
  endtask

  task automatic wait_sel(input logic [3:0] s, input string nm);
    int n;
    n = 0;
    while (bus.io_sel !== s && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) timeout_fail(nm);
  endtask

  task automatic wait_drive(input string nm);
    int n;
    n = 0;
    while (bus.io_sel === 4'hF && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) timeout_fail(nm);
  endtask

  // Compare one whole frame against the scoreboard; align=1 skips to the
  // next frame boundary first, align=0 starts at the next guard interval
  task automatic check_frame(input bit align, input string nm);
    exp_t e;
    if (align) wait_sel(4'b0111, {nm, "_align"});
    wait_sel(4'hF, {nm, "_guard0"});
    for (int d = 0; d < DIGITS; d++) begin
      wait_drive({nm, "_drive"});
      if (sb.size() == 0) begin
        timeout_fail({nm, "_sb_empty"});
      end else begin
        e = sb.pop_front();
        check($sformatf("%s_d%0d_sel", nm, d), {28'h0, bus.io_sel}, {28'h0, e.sel});
        check($sformatf("%s_d%0d_seg", nm, d), {24'h0, bus.io_seg}, {24'h0, e.seg});
      end
      wait_sel(4'hF, {nm, "_guard"});
    end
  endtask

  // Continuous checks: never two digits selected; two guard cycles after each tick
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if ($countones(~bus.io_sel) > 1) begin
        failures++;
        $display("FAIL onehot: io_sel=%b required at most one low bit", bus.io_sel);
      end
      if (bus.scan_tick === 1'b1) since_tick = 0;
      else if (since_tick < 100) since_tick++;
      if (since_tick == 1 || since_tick == 2) begin
        checks++;
        if (bus.io_sel !== 4'hF) begin
          failures++;
          $display("FAIL guard: io_sel=%b required 1111 at guard cycle %0d", bus.io_sel, since_tick);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int ticks;
    int lit;

    vecs[0] = '{16'h1234, 4'b0001, 1'b0, 32'hF9A4B019};
    vecs[1] = '{16'h0005, 4'b0000, 1'b1, 32'hFFFFFF92};
    vecs[2] = '{16'h0000, 4'b0000, 1'b1, 32'hFFFFFFC0};
    vecs[3] = '{16'hABCD, 4'b1010, 1'b0, 32'h088346A1};
    vecs[4] = '{16'h0F00, 4'b1000, 1'b1, 32'h7F8EC0C0};
    vecs[5] = '{16'h10E0, 4'b0000, 1'b1, 32'hF9C086C0};
    vecs[6] = '{16'h0000, 4'b0100, 1'b0, 32'hC040C0C0};
    vecs[7] = '{16'h8907, 4'b0000, 1'b0, 32'h8090C0F8};
    vecs[8] = '{16'h0036, 4'b0000, 1'b1, 32'hFFFFB082};

    rst = 1'b1;
    bus.enable = 1'b1;
    bus.load = 1'b0;
    bus.value = '0;
    bus.dp = '0;
    bus.blank_lz = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_sel", {28'h0, bus.io_sel}, 32'hF);
    check("rst_seg", {24'h0, bus.io_seg}, 32'hFF);
    check("rst_tick", {31'h0, bus.scan_tick}, 32'h0);
    mon_en = 1'b1;
    rst = 1'b0;

    // First tick on the 8th edge after release; digit 0 already shows "0"
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.scan_tick === 1'b1) begin
        k = i;
        break;
      end
    end
    check("first_tick_cycle", k, 8);
    check("first_d0_sel", {28'h0, bus.io_sel}, 32'hE);
    check("first_d0_seg", {24'h0, bus.io_seg}, 32'hC0);

    // Mid-frame load: rest of the current frame still shows zeros
    @(negedge clk);
    bus.load = 1'b1; bus.value = 16'h1234; bus.dp = 4'b0001; bus.blank_lz = 1'b0;
    push_frame(32'hF9A4B019);
    @(negedge clk);
    bus.load = 1'b0;
    wait_sel(4'b1011, "old_d2_wait");
    check("old_frame_d2_seg", {24'h0, bus.io_seg}, 32'hC0);
    wait_sel(4'b0111, "old_d3_wait");
    check("old_frame_d3_seg", {24'h0, bus.io_seg}, 32'hC0);
    check_frame(1'b0, "midload");

    // Table of display patterns
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      bus.load = 1'b1; bus.value = vecs[i].value; bus.dp = vecs[i].dp; bus.blank_lz = vecs[i].blz;
      push_frame(vecs[i].exp_seg);
      @(negedge clk);
      bus.load = 1'b0;
      repeat (2 * FRAME) @(negedge clk);
      check_frame(1'b1, $sformatf("vec%0d", i));
    end

    // Load A one cycle before the wrap, B on the wrap cycle
    k = 0;
    while (!(bus.scan_tick === 1'b1 && bus.io_sel === 4'b1011) && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) timeout_fail("wrap_find");
    repeat (DIV - 2) @(negedge clk);
    bus.load = 1'b1; bus.value = 16'h4321; bus.dp = 4'b0000; bus.blank_lz = 1'b0;
    push_frame(32'h99B0A4F9);
    @(negedge clk);
    bus.value = 16'h00A0; bus.dp = 4'b0001; bus.blank_lz = 1'b1;
    push_frame(32'hFFFF8840);
    @(negedge clk);
    bus.load = 1'b0;
    check("wrap_tick", {31'h0, bus.scan_tick}, 32'h1);
    check("wrap_sel", {28'h0, bus.io_sel}, 32'h7);
    check_frame(1'b0, "frameA");
    check_frame(1'b0, "frameB");

    // Enable drop mid-slot: dark next cycle, scanning frozen
    wait_drive("en_drive");
    bus.enable = 1'b0;
    @(negedge clk);
    check("dis_sel", {28'h0, bus.io_sel}, 32'hF);
    check("dis_seg", {24'h0, bus.io_seg}, 32'hFF);
    check("dis_tick", {31'h0, bus.scan_tick}, 32'h0);
    ticks = 0;
    lit = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.scan_tick !== 1'b0) ticks++;
      if (bus.io_sel !== 4'hF || bus.io_seg !== 8'hFF) lit++;
    end
    check("dis_ticks", ticks, 0);
    check("dis_lit_cycles", lit, 0);
    bus.enable = 1'b1;
    @(negedge clk);
    check("reen_g0_sel", {28'h0, bus.io_sel}, 32'hF);
    @(negedge clk);
    check("reen_g1_sel", {28'h0, bus.io_sel}, 32'hF);
    @(negedge clk);
    check("reen_d0_sel", {28'h0, bus.io_sel}, 32'hE);
    check("reen_d0_seg", {24'h0, bus.io_seg}, 32'h40);

    // Reset mid-slot with pending data: dark at once, pending discarded
    @(negedge clk);
    bus.load = 1'b1; bus.value = 16'hBEEF; bus.dp = 4'b1111; bus.blank_lz = 1'b0;
    @(negedge clk);
    bus.load = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_sel", {28'h0, bus.io_sel}, 32'hF);
    check("arst_seg", {24'h0, bus.io_seg}, 32'hFF);
    check("arst_tick", {31'h0, bus.scan_tick}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    push_frame(32'hC0C0C0C0);
    push_frame(32'hC0C0C0C0);
    check_frame(1'b1, "post_rst1");
    check_frame(1'b0, "post_rst2");
    check("sb_drained", sb.size(), 0);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seg7_scan_mux.md
Name: seg7_scan_mux

Overview:
Time-multiplexed seven-segment driver for the IO element's 4-digit display. Consumes a hex value, per-digit decimal points, and a load strobe from core logic. Drives io_sel/io_seg directly at the top level.
Double-buffers display data so updates land only on frame boundaries (no tearing). Inserts an all-off guard interval at each digit switch to suppress ghosting.

Parameters:
DIGITS, 4, number of digits scanned (io_sel width)
DIV, 50000, clk cycles per digit slot (100 MHz -> 2 kHz slot, 500 Hz frame); legal range DIV >= 2
BLANK_CYCLES, 8, guard cycles at slot start with all digits deselected; constraint BLANK_CYCLES < DIV

Ports:
clk  input  1  design clock
rst  input  1  asynchronous, active-high reset
enable  input  1  1 = scan; 0 = display dark, scan counters held at 0
load  input  1  single-cycle strobe: capture value/dp/blank_lz into pending buffer
value  input  4*DIGITS  hex nibbles; digit i = value[4i+3:4i], digit 0 rightmost
dp  input  DIGITS  decimal point per digit, 1 = lit
blank_lz  input  1  1 = suppress leading zeros
io_sel  output  DIGITS  digit select, active-low, registered
io_seg  output  8  segments, active-low, registered; [0]=a .. [6]=g, [7]=dp
scan_tick  output  1  one-cycle pulse on every digit advance

Behaviour:
- Reset (async, while rst=1):
  - io_sel = all 1s, io_seg = 8'hFF, scan_tick = 0.
  - Prescaler cnt = 0, digit index dig = 0.
  - Active and pending buffers = 0; pending_valid = 0.
  - After release, display shows "0000" (blank_lz = 0).
- Prescaler:
  - cnt counts 0..DIV-1 while enable=1.
  - At cnt == DIV-1: cnt <= 0; dig <= dig+1, wrapping DIGITS-1 -> 0; scan_tick = 1 that cycle (registered, same edge as the cnt/dig update).
- Slot FSM (derived from cnt):
  - GUARD while cnt < BLANK_CYCLES.
  - DRIVE otherwise.
- Outputs are registered from the current cnt/dig/active state, so they lag by 1 cycle.
  - GUARD: io_sel all 1s, io_seg = 8'hFF.
  - DRIVE: io_sel[dig] = 0, all other io_sel bits = 1; io_seg = ~{dp_a[dig], hexseg(nibble)}.
- Hex table, gfedcba with 1 = on:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- Leading-zero suppression (active buffer blank_lz = 1):
  - Digit k > 0 is blanked (a..g off) if it and all higher digits are 0.
  - Digit 0 is never blanked.
  - dp is unaffected by blanking.
- Double buffer:
  - load=1 writes value/dp/blank_lz into pending and sets pending_valid.
  - A later load overwrites pending.
  - On the wrap edge (dig DIGITS-1 -> 0) with pending_valid = 1: active <= pending, pending_valid <= 0.
  - Load on the same cycle as the wrap: the old pending transfers to active; the new data goes into pending and pending_valid stays 1.
  - Load is accepted regardless of enable.
- enable = 0:
  - Next cycle: io_sel all 1s, io_seg = 8'hFF, scan_tick = 0.
  - cnt and dig are forced to 0; no transfer occurs.
  - Re-enable starts at digit 0 in GUARD.
- Reset mid-scan: immediate dark outputs; all state cleared, including pending.

Test Plan:
- DIGITS=4, DIV=8, BLANK_CYCLES=2 for all scenarios.
- Reset, enable=1: during rst, io_sel=4'b1111, io_seg=8'hFF. After release, first scan_tick at cycle 8. Digit 0 shows 0: io_sel=4'b1110, io_seg=8'hC0.
- Load value=16'h1234, dp=4'b0001 mid-frame: current frame unchanged. After next wrap, digit 0 shows io_seg=8'h19 (4 with dp); digit 3 shows io_sel=4'b0111, io_seg=8'hF9 (1).
- Load 16'h0005 with blank_lz=1: digits 3..1 show io_seg=8'hFF, digit 0 shows 8'h92. Then load 16'h0000, blank_lz=1: digit 0 shows 8'hC0, others 8'hFF.
- Each slot: the first 2 output cycles after scan_tick have io_sel=4'b1111. Exactly one io_sel bit is low in the other 6. Never two bits low.
- Load A one cycle before the wrap and load B on the wrap cycle: frame shows A; the next frame shows B.
- Drop enable mid-slot: dark next cycle, no scan_tick. Re-enable: digit 0 after 2 guard cycles. Assert rst mid-slot: outputs dark immediately; display returns to "0000".
